// File: rtl/conv55_window_gen.sv
// Streaming 5x5 sliding-window generator: four line buffers feed a 5x5 register
// window; every non-padded window position is presented as 25 parallel taps.
module conv55_window_gen #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic [25*DATA_W-1:0]       win_data,
    output logic                       win_valid,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned ColW = $clog2(IMG_W);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowFour = RowW'(4);
    localparam logic [ColW-1:0] ColFour = ColW'(4);

    logic [RowW-1:0]   row_q, row_d, cur_row;
    logic [ColW-1:0]   col_q, col_d, cur_col;

    // lb_q[0] holds the previous line, lb_q[3] the line four rows up.
    logic [DATA_W-1:0] lb_q  [4][IMG_W];
    logic [DATA_W-1:0] lb_rd [4];
    logic [DATA_W-1:0] col_in [5];

    logic [DATA_W-1:0] win_q [5][5];
    logic [DATA_W-1:0] win_d [5][5];

    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [RowW-1:0]   win_row_q, win_row_d;
    logic [ColW-1:0]   win_col_q, win_col_d;

    // Position of the pixel being accepted and the counter advance.
    always_comb begin
        cur_row = in_sof ? '0 : row_q;
        cur_col = in_sof ? '0 : col_q;
        row_d   = row_q;
        col_d   = col_q;
        if (in_valid) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
            end else begin
                col_d = cur_col + ColW'(1);
                row_d = cur_row;
            end
        end
    end

    // Read all four lines at the current column; row 0 of the window is the oldest line.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lb_rd[i] = lb_q[i][cur_col];
        end
        for (int r = 0; r < 4; r++) begin
            col_in[r] = lb_rd[3-r];
        end
        col_in[4] = in_data;
    end

    // Window shift: columns move left, the new 5-pixel column enters at column 4.
    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][4] = col_in[r];
            end
        end
    end

    // Output qualifiers for the window formed by this acceptance.
    always_comb begin
        win_valid_d  = in_valid && (cur_row >= RowFour) && (cur_col >= ColFour);
        frame_done_d = in_valid && (cur_row == RowLast) && (cur_col == ColLast);
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        if (win_valid_d) begin
            win_row_d = cur_row - RowFour;
            win_col_d = cur_col - ColFour;
        end
    end

    // Line-buffer cascade; contents are not reset since the counters gate validity.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_q[0][cur_col] <= in_data;
            lb_q[1][cur_col] <= lb_rd[0];
            lb_q[2][cur_col] <= lb_rd[1];
            lb_q[3][cur_col] <= lb_rd[2];
        end
    end

    // Counters, window registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_q        <= win_d;
        end
    end

    // Pack taps: tap k = r*5+c.
    always_comb begin
        win_data = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_data[DATA_W*(r*5+c) +: DATA_W] = win_q[r][c];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv55_window_gen.sv
// Self-checking bench: image-addressed reference model, scenario tasks.
module tb_conv55_window_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sof;
    logic [5:0]   in_data;

    logic [149:0] wd8, wd5;
    logic         wv8, wv5, fd8, fd5;
    logic [2:0]   wr8, wc8, wr5, wc5;

    always #5 clk = ~clk;

    conv55_window_gen #(.DATA_W(6), .IMG_W(8), .IMG_H(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_data(wd8), .win_valid(wv8), .win_row(wr8), .win_col(wc8), .frame_done(fd8)
    );

    conv55_window_gen #(.DATA_W(6), .IMG_W(5), .IMG_H(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_data(wd5), .win_valid(wv5), .win_row(wr5), .win_col(wc5), .frame_done(fd5)
    );

    // Observe whichever instance the current test targets.
    logic         sel;
    logic [149:0] o_data;
    logic         o_valid, o_fd;
    logic [2:0]   o_row, o_col;
    assign o_data  = sel ? wd5 : wd8;
    assign o_valid = sel ? wv5 : wv8;
    assign o_fd    = sel ? fd5 : fd8;
    assign o_row   = sel ? wr5 : wr8;
    assign o_col   = sel ? wc5 : wc8;

    int checks = 0;
    int failures = 0;

    // Reference model: image indexed by position plus a raster position counter.
    int           mw, mh, mr, mc, pix_idx, first_idx, nfd;
    logic [5:0]   img [8][8];
    logic [149:0] exp_q[$];
    logic [149:0] obs_q[$];
    logic [149:0] ref_q[$];

    function automatic logic [5:0] tap(input logic [149:0] w, input int k);
        return w[6*k +: 6];
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [5:0] d);
        int R, C;
        logic ev, ef;
        logic [149:0] ew;
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        ev = 1'b0; ef = 1'b0; ew = '0; R = 0; C = 0;
        if (v) begin
            if (s) begin
                mr = 0; mc = 0; pix_idx = 0;
            end else begin
                pix_idx++;
            end
            R = mr; C = mc;
            img[R][C] = d;
            ev = (R >= 4 && C >= 4);
            ef = (R == mh - 1 && C == mw - 1);
            if (ev) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        ew[6*(r*5+c) +: 6] = img[R-4+r][C-4+c];
            end
            mc++;
            if (mc == mw) begin
                mc = 0; mr++;
                if (mr == mh) mr = 0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== ev) begin
            failures++;
            $display("FAIL win_valid pos=(%0d,%0d) got=%b want=%b", R, C, o_valid, ev);
        end
        checks++;
        if (o_fd !== ef) begin
            failures++;
            $display("FAIL frame_done pos=(%0d,%0d) got=%b want=%b", R, C, o_fd, ef);
        end
        if (ev) begin
            checks++;
            if (o_data !== ew) begin
                failures++;
                $display("FAIL win_data pos=(%0d,%0d) got=%h want=%h", R, C, o_data, ew);
            end
            checks++;
            if (o_row !== 3'(R - 4)) begin
                failures++;
                $display("FAIL win_row got=%0d want=%0d", o_row, R - 4);
            end
            checks++;
            if (o_col !== 3'(C - 4)) begin
                failures++;
                $display("FAIL win_col got=%0d want=%0d", o_col, C - 4);
            end
            exp_q.push_back(ew);
        end
        if (o_valid === 1'b1) begin
            obs_q.push_back(o_data);
            if (first_idx < 0) first_idx = pix_idx;
        end
        if (o_fd === 1'b1) nfd++;
    endtask

    // kind: 0 ramp, 1 inverted ramp, 2 random; gap: 0 none, 1 three after every 5th, 2 random
    task automatic run_frame(input int kind, input int gap, input logic use_sof);
        logic [5:0] d;
        for (int i = 0; i < mw * mh; i++) begin
            case (kind)
                0:       d = 6'(i);
                1:       d = 6'(63 - i);
                default: d = 6'($urandom);
            endcase
            cycle(1'b1, use_sof && (i == 0), d);
            if (gap == 1 && (i % 5) == 4) repeat (3) cycle(1'b0, 1'b0, 6'($urandom));
            if (gap == 2 && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 4)) cycle(1'b0, 1'b0, 6'($urandom));
        end
    endtask

    task automatic start(input int w, input int h);
        sel = (w == 5);
        mw = w; mh = h;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mr = 0; mc = 0; pix_idx = -1; first_idx = -1; nfd = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        rst = 1'b1;
        #3;
        checks++;
        if ({wv8, fd8, wr8, wc8} !== 8'h0 || wd8 !== '0) begin
            failures++;
            $display("FAIL reset_dut8 got v=%b fd=%b r=%0d c=%0d d=%h want all 0",
                     wv8, fd8, wr8, wc8, wd8);
        end
        checks++;
        if ({wv5, fd5, wr5, wc5} !== 8'h0 || wd5 !== '0) begin
            failures++;
            $display("FAIL reset_dut5 got v=%b fd=%b r=%0d c=%0d d=%h want all 0",
                     wv5, fd5, wr5, wc5, wd5);
        end
    endtask

    task automatic compare_to_ref(input string name);
        checks++;
        if (obs_q.size() != ref_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d", name, obs_q.size(), ref_q.size());
        end else begin
            for (int i = 0; i < ref_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== ref_q[i]) begin
                    failures++;
                    $display("FAIL %s_win%0d got=%h want=%h", name, i, obs_q[i], ref_q[i]);
                end
            end
        end
    endtask

    task automatic test_ramp();
        start(8, 8);
        run_frame(0, 0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 6'd0);
        checks++;
        if (obs_q.size() != 16) begin
            failures++;
            $display("FAIL ramp_count got=%0d want=16", obs_q.size());
        end
        checks++;
        if (first_idx != 36) begin
            failures++;
            $display("FAIL ramp_first_idx got=%0d want=36", first_idx);
        end
        checks++;
        if (tap(obs_q[0], 0) !== 6'd0 || tap(obs_q[0], 12) !== 6'd18 ||
            tap(obs_q[0], 24) !== 6'd36) begin
            failures++;
            $display("FAIL ramp_first taps got=%0d/%0d/%0d want=0/18/36",
                     tap(obs_q[0], 0), tap(obs_q[0], 12), tap(obs_q[0], 24));
        end
        checks++;
        if (tap(obs_q[15], 24) !== 6'd63 || tap(obs_q[15], 0) !== 6'd27) begin
            failures++;
            $display("FAIL ramp_last taps got=%0d/%0d want=63/27",
                     tap(obs_q[15], 24), tap(obs_q[15], 0));
        end
        checks++;
        if (nfd != 1) begin
            failures++;
            $display("FAIL ramp_frame_done got=%0d want=1", nfd);
        end
        ref_q = exp_q;
    endtask

    task automatic test_gaps();
        start(8, 8);
        run_frame(0, 1, 1'b1);
        cycle(1'b0, 1'b0, 6'd0);
        compare_to_ref("gaps");
    endtask

    task automatic test_random();
        start(8, 8);
        run_frame(2, 2, 1'b1);
        run_frame(2, 2, 1'b0);
        checks++;
        if (obs_q.size() != 32 || nfd != 2) begin
            failures++;
            $display("FAIL random_counts got win=%0d fd=%0d want win=32 fd=2", obs_q.size(), nfd);
        end
    endtask

    task automatic test_back_to_back();
        start(8, 8);
        run_frame(0, 0, 1'b1);
        run_frame(1, 0, 1'b0);
        cycle(1'b0, 1'b0, 6'd0);
        checks++;
        if (obs_q.size() != 32) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=32", obs_q.size());
        end
        checks++;
        if (tap(obs_q[16], 0) !== 6'd63 || tap(obs_q[16], 24) !== 6'd27) begin
            failures++;
            $display("FAIL b2b_first taps got=%0d/%0d want=63/27",
                     tap(obs_q[16], 0), tap(obs_q[16], 24));
        end
        checks++;
        if (nfd != 2) begin
            failures++;
            $display("FAIL b2b_frame_done got=%0d want=2", nfd);
        end
    endtask

    task automatic test_async_reset();
        start(8, 8);
        for (int i = 0; i <= 46; i++) cycle(1'b1, i == 0, 6'(i));
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({wv8, fd8, wr8, wc8} !== 8'h0 || wd8 !== '0) begin
            failures++;
            $display("FAIL async_reset got v=%b fd=%b r=%0d c=%0d d=%h want all 0",
                     wv8, fd8, wr8, wc8, wd8);
        end
        @(negedge clk);
        rst = 1'b0;
        mr = 0; mc = 0; pix_idx = -1; first_idx = -1; nfd = 0;
        obs_q.delete();
        run_frame(0, 0, 1'b0);
        cycle(1'b0, 1'b0, 6'd0);
        compare_to_ref("after_reset");
    endtask

    task automatic test_sof_restart();
        start(8, 8);
        for (int i = 0; i < 19; i++) cycle(1'b1, i == 0, 6'($urandom));
        first_idx = -1;
        obs_q.delete();
        run_frame(0, 0, 1'b1);
        cycle(1'b0, 1'b0, 6'd0);
        checks++;
        if (first_idx != 36) begin
            failures++;
            $display("FAIL sof_first_idx got=%0d want=36", first_idx);
        end
        compare_to_ref("sof");
    endtask

    task automatic test_small();
        start(5, 5);
        run_frame(0, 0, 1'b1);
        run_frame(0, 0, 1'b0);
        cycle(1'b0, 1'b0, 6'd0);
        checks++;
        if (obs_q.size() != 2 || nfd != 2) begin
            failures++;
            $display("FAIL small_counts got win=%0d fd=%0d want win=2 fd=2", obs_q.size(), nfd);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 25; k++) begin
                checks++;
                if (tap(obs_q[f], k) !== 6'(k)) begin
                    failures++;
                    $display("FAIL small_tap f=%0d k=%0d got=%0d want=%0d",
                             f, k, tap(obs_q[f], k), k);
                end
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_ramp();
        test_gaps();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_sof_restart();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv55_window_gen.md
Name: conv55_window_gen

Overview:
Streaming 5x5 sliding-window generator that sits directly upstream of the 5x5 6-bit convolution stage. It accepts one raster-order pixel per cycle and buffers 4 full image lines plus a 5x5 register window. For every valid (non-padded) window position it presents the 25 taps in parallel, so the next stage can multiply them against the 25 kernel taps. The output is valid-only; there is no backpressure, because the downstream stage accepts a window every cycle.

Parameters:
DATA_W, 6, pixel width in bits
IMG_W, 32, image width in pixels (>=5)
IMG_H, 32, image height in lines (>=5)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  pixel qualifier; pixel accepted on any cycle with in_valid=1
in_sof  input  1  start of frame; sampled only when in_valid=1
in_data  input  DATA_W  pixel value
win_data  output  25*DATA_W  taps; tap k = win_data[DATA_W*k +: DATA_W], k=r*5+c
win_valid  output  1  win_data holds a complete, valid window
win_row  output  $clog2(IMG_H)  image row of the window's top-left tap
win_col  output  $clog2(IMG_W)  image column of the window's top-left tap
frame_done  output  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async, rst=1): win_valid=0, frame_done=0, win_data=0, win_row=0, win_col=0. Column and row counters are 0. Window registers are cleared. Line-buffer RAM contents are not cleared; the counters gate validity, so stale data is never emitted. Reset mid-frame drops the partial frame; the next accepted pixel is (0,0).
- Tap ordering: r=0 is the oldest line (top) and r=4 is the current line. c=0 is the oldest column (left) and c=4 is the newest pixel. So tap 0 = (R-4,C-4) and tap 24 = (R,C) for a pixel accepted at (R,C). This matches in_data_0..in_data_24 of the convolution stage.
- Line buffers: 4 memories, each IMG_W x DATA_W, addressed by the column counter.
  - On an accepted pixel at column C: read all 4 lines at address C, shift the cascade (line3<=line2<=line1<=line0<=in_data), and shift the 5-entry column {line3,line2,line1,line0,in_data} into window column 4. Columns 0..3 move left by one.
  - Read-before-write at the same address is required.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0 with row+1.
  - row wraps IMG_H-1 -> 0 at the end of the frame.
  - in_valid=1 with in_sof=1 forces the accepted pixel to be (0,0), whatever the counters held.
- Output timing: a window is emitted when the accepted pixel has R>=4 and C>=4.
  - win_valid=1 on the cycle after acceptance (latency 1), with win_row=R-4 and win_col=C-4.
  - Windows straddling a line boundary (C<4) are never emitted. There is no padding.
  - Windows per frame = (IMG_W-4)*(IMG_H-4).
- frame_done = 1 in the same cycle as the window for pixel (IMG_H-1, IMG_W-1). Otherwise 0.
- in_valid=0: no state changes. win_valid and frame_done are 0 the next cycle, and win_data holds its last value. Gaps of any length anywhere in the frame must not alter the emitted window sequence.
- Back-to-back frames with no idle cycle are supported. The first line-4 windows of frame N+1 use only frame N+1 data, because lines 0..3 have been rewritten by then.
- An in_sof mid-frame restarts the frame. Line buffers are not flushed; validity is governed by row>=4 after the restart.

Test Plan:
1. IMG_W=IMG_H=8, pixel p(r,c)=r*8+c streamed continuously after reset. First win_valid arrives 1 cycle after pixel 36 is accepted, with tap0=0, tap12=18, tap24=36, win_row=0, win_col=0. Exactly 16 windows are emitted, and the last has tap24=63, tap0=27, frame_done=1.
2. Same frame with in_valid low for 3 cycles after every 5th pixel. The window sequence is identical to scenario 1, and win_valid=0 in the gap cycles.
3. Two back-to-back frames, the second with p'(r,c)=63-(r*8+c). The second frame's first window has tap0=63, tap24=27 and contains no first-frame values. frame_done pulses twice.
4. rst asserted asynchronously mid-row 5, then the frame restarts. Outputs are 0 immediately. No windows are emitted until the new pixel (4,4), and those windows equal scenario 1.
5. in_sof pulsed at the 20th pixel of a frame. Counters resync to (0,0), and the next window appears 1 cycle after 36 pixels counted from the sof pixel, with correct taps.
6. IMG_W=IMG_H=5 edge case. Exactly one window per frame, with win_valid and frame_done together, tap k = k for the ramp input p=r*5+c.
